// File: rtl/pad_cfg_ctrl_if.sv
// Configuration request channel and registered pad-ring controls for pad_cfg_ctrl.
// The requester holds the request fields stable while cfg_valid is high and cfg_ready is low.
interface pad_cfg_ctrl_if #(
  parameter int NUM_PADS = 15
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [3:0]          cfg_pad_idx;
  logic                cfg_dir;
  logic [1:0]          cfg_pull;
  logic                cfg_done;
  logic                cfg_err;
  logic [NUM_PADS-1:0] oe_bidir;
  logic [NUM_PADS-1:0] ie_bidir;
  logic [NUM_PADS-1:0] pu_bidir;
  logic [NUM_PADS-1:0] pd_bidir;

  modport master (
    output cfg_valid, cfg_pad_idx, cfg_dir, cfg_pull,
    input  cfg_ready, cfg_done, cfg_err,
    input  oe_bidir, ie_bidir, pu_bidir, pd_bidir
  );

  modport slave (
    input  cfg_valid, cfg_pad_idx, cfg_dir, cfg_pull,
    output cfg_ready, cfg_done, cfg_err,
    output oe_bidir, ie_bidir, pu_bidir, pd_bidir
  );
endinterface

// File: rtl/pad_cfg_ctrl.sv
// Runtime pad configuration sequencer: applies per-pad oe/ie/pull settings, floating a pad
// for SETTLE_CYCLES before any direction change so drivers never contend.
module pad_cfg_ctrl #(
  parameter int                  NUM_PADS      = 15,
  parameter int                  SETTLE_CYCLES = 4,
  parameter logic [NUM_PADS-1:0] RESET_OE      = NUM_PADS'(15'h7FF0),
  parameter logic [NUM_PADS-1:0] RESET_IE      = NUM_PADS'(15'h000F)
) (
  input  logic           clk,
  input  logic           rst,
  pad_cfg_ctrl_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic                dir_q, dir_d;
  logic [1:0]          pull_q, pull_d;
  logic [NUM_PADS-1:0] oe_q, oe_d;
  logic [NUM_PADS-1:0] ie_q, ie_d;
  logic [NUM_PADS-1:0] pu_q, pu_d;
  logic [NUM_PADS-1:0] pd_q, pd_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [NUM_PADS-1:0] sel_in;
  logic [NUM_PADS-1:0] sel_cap;
  logic                req_legal;
  logic                dir_same;

  function automatic logic [NUM_PADS-1:0] pad_sel(input logic [3:0] idx);
    logic [NUM_PADS-1:0] s;
    s = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      s[p] = (idx == 4'(p));
    end
    return s;
  endfunction

  function automatic logic is_legal(input logic [3:0] idx, input logic [1:0] pull);
    return ({1'b0, idx} < 5'(NUM_PADS)) && (pull != 2'b11);
  endfunction

  // Replace the selected pad's bit with val, leave every other pad untouched.
  function automatic logic [NUM_PADS-1:0] merge(input logic [NUM_PADS-1:0] vec,
                                                input logic [NUM_PADS-1:0] sel,
                                                input logic                val);
    return (vec & ~sel) | (sel & {NUM_PADS{val}});
  endfunction

  function automatic logic pu_val(input logic dir, input logic [1:0] pull);
    return !dir && (pull == 2'b01);
  endfunction

  function automatic logic pd_val(input logic dir, input logic [1:0] pull);
    return !dir && (pull == 2'b10);
  endfunction

  assign sel_in    = pad_sel(bus.cfg_pad_idx);
  assign sel_cap   = pad_sel(idx_q);
  assign req_legal = is_legal(bus.cfg_pad_idx, bus.cfg_pull);
  assign dir_same  = (bus.cfg_dir == |(oe_q & sel_in));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    pull_d  = pull_q;
    oe_d    = oe_q;
    ie_d    = ie_q;
    pu_d    = pu_q;
    pd_d    = pd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (dir_same) begin
            oe_d   = merge(oe_q, sel_in, bus.cfg_dir);
            ie_d   = merge(ie_q, sel_in, !bus.cfg_dir);
            pu_d   = merge(pu_q, sel_in, pu_val(bus.cfg_dir, bus.cfg_pull));
            pd_d   = merge(pd_q, sel_in, pd_val(bus.cfg_dir, bus.cfg_pull));
            done_d = 1'b1;
          end else begin
            // Float the pad first; the request is captured so later input changes are ignored.
            oe_d    = merge(oe_q, sel_in, 1'b0);
            ie_d    = merge(ie_q, sel_in, 1'b0);
            pu_d    = merge(pu_q, sel_in, 1'b0);
            pd_d    = merge(pd_q, sel_in, 1'b0);
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            idx_d   = bus.cfg_pad_idx;
            dir_d   = bus.cfg_dir;
            pull_d  = bus.cfg_pull;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          oe_d    = merge(oe_q, sel_cap, dir_q);
          ie_d    = merge(ie_q, sel_cap, !dir_q);
          pu_d    = merge(pu_q, sel_cap, pu_val(dir_q, pull_q));
          pd_d    = merge(pd_q, sel_cap, pd_val(dir_q, pull_q));
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      pull_q  <= '0;
      oe_q    <= RESET_OE;
      ie_q    <= RESET_IE;
      pu_q    <= '0;
      pd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      pull_q  <= pull_d;
      oe_q    <= oe_d;
      ie_q    <= ie_d;
      pu_q    <= pu_d;
      pd_q    <= pd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.cfg_done  = done_q;
  assign bus.cfg_err   = err_q;
  assign bus.oe_bidir  = oe_q;
  assign bus.ie_bidir  = ie_q;
  assign bus.pu_bidir  = pu_q;
  assign bus.pd_bidir  = pd_q;

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed bench for pad_cfg_ctrl: requests feed a scoreboard of expected pad vectors that a
// monitor pops on every cfg_done/cfg_err pulse; settle timing and reset are checked inline.
module tb_pad_cfg_ctrl;
  localparam int          NP  = 15;
  localparam logic [14:0] ROE = 15'h7FF0;
  localparam logic [14:0] RIE = 15'h000F;

  typedef struct {
    logic        err;
    logic [14:0] oe;
    logic [14:0] ie;
    logic [14:0] pu;
    logic [14:0] pd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pad_cfg_ctrl_if #(.NUM_PADS(NP)) bus ();

  pad_cfg_ctrl #(
    .NUM_PADS(NP),
    .SETTLE_CYCLES(4),
    .RESET_OE(ROE),
    .RESET_IE(RIE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   err_seen = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  logic [14:0] m_oe, m_ie, m_pu, m_pd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_oe = ROE;
    m_ie = RIE;
    m_pu = '0;
    m_pd = '0;
  endtask

  task automatic drive(input logic [3:0] idx, input logic dir, input logic [1:0] pull);
    bus.cfg_pad_idx = idx;
    bus.cfg_dir     = dir;
    bus.cfg_pull    = pull;
    bus.cfg_valid   = 1'b1;
  endtask

  // Waits (bounded) for the accepting edge, records the expected outcome, returns just after it.
  task automatic wait_accept(output int w);
    exp_t e;
    logic legal;
    w = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cfg_ready) break;
      w++;
    end
    if (!bus.cfg_ready) begin
      chk("accept_timeout", {31'd0, bus.cfg_ready}, 32'd1);
      return;
    end
    legal = (bus.cfg_pad_idx < 4'd15) && (bus.cfg_pull != 2'b11);
    if (legal) begin
      m_oe[bus.cfg_pad_idx] = bus.cfg_dir;
      m_ie[bus.cfg_pad_idx] = !bus.cfg_dir;
      m_pu[bus.cfg_pad_idx] = !bus.cfg_dir && (bus.cfg_pull == 2'b01);
      m_pd[bus.cfg_pad_idx] = !bus.cfg_dir && (bus.cfg_pull == 2'b10);
    end
    e.err = !legal;
    e.oe  = m_oe;
    e.ie  = m_ie;
    e.pu  = m_pu;
    e.pd  = m_pd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Counts cycles pad idx is floated until cfg_done, starting just after the accepting edge.
  task automatic wait_done(input int idx, output int floats);
    floats = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cfg_done) break;
      if (!bus.oe_bidir[idx] && !bus.ie_bidir[idx]) floats++;
      chk("ready_low_in_settle", {31'd0, bus.cfg_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("done_reached", {31'd0, bus.cfg_done}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("inv_oe_ie", {17'd0, bus.oe_bidir & bus.ie_bidir}, 32'd0);
      chk("inv_pu_pd", {17'd0, bus.pu_bidir & bus.pd_bidir}, 32'd0);
      chk("inv_oe_pull", {17'd0, bus.oe_bidir & (bus.pu_bidir | bus.pd_bidir)}, 32'd0);
      if (bus.cfg_done) done_seen++;
      if (bus.cfg_err) err_seen++;
      if (bus.cfg_done || bus.cfg_err) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_pulse", {30'd0, bus.cfg_done, bus.cfg_err}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_kind", {30'd0, bus.cfg_done, bus.cfg_err}, e.err ? 32'd1 : 32'd2);
          chk("sb_oe", {17'd0, bus.oe_bidir}, {17'd0, e.oe});
          chk("sb_ie", {17'd0, bus.ie_bidir}, {17'd0, e.ie});
          chk("sb_pu", {17'd0, bus.pu_bidir}, {17'd0, e.pu});
          chk("sb_pd", {17'd0, bus.pd_bidir}, {17'd0, e.pd});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int f;
    bus.cfg_valid   = 1'b0;
    bus.cfg_pad_idx = '0;
    bus.cfg_dir     = 1'b0;
    bus.cfg_pull    = '0;
    model_reset();

    // Reset asserted between edges must act immediately.
    #2 rst = 1'b1;
    #1;
    chk("rst_oe", {17'd0, bus.oe_bidir}, {17'd0, ROE});
    chk("rst_ie", {17'd0, bus.ie_bidir}, {17'd0, RIE});
    chk("rst_pu", {17'd0, bus.pu_bidir}, 32'd0);
    chk("rst_pd", {17'd0, bus.pd_bidir}, 32'd0);
    chk("rst_ready", {31'd0, bus.cfg_ready}, 32'd1);
    chk("rst_done_err", {30'd0, bus.cfg_done, bus.cfg_err}, 32'd0);
    mon_en = 1'b1;
    #19 rst = 1'b0;
    @(posedge clk);
    #1;

    // Pull-only change on an input pad.
    drive(4'd2, 1'b0, 2'b01);
    wait_accept(w);
    bus.cfg_valid = 1'b0;
    chk("pull_done", {31'd0, bus.cfg_done}, 32'd1);
    chk("pull_ready", {31'd0, bus.cfg_ready}, 32'd1);
    chk("pull_pu2", {31'd0, bus.pu_bidir[2]}, 32'd1);
    chk("pull_pd2", {31'd0, bus.pd_bidir[2]}, 32'd0);
    chk("pull_ie2", {31'd0, bus.ie_bidir[2]}, 32'd1);
    @(posedge clk);
    #1;
    chk("pull_done_once", {31'd0, bus.cfg_done}, 32'd0);

    // Direction change output -> input with pull-down.
    drive(4'd5, 1'b0, 2'b10);
    wait_accept(w);
    bus.cfg_valid = 1'b0;
    wait_done(5, f);
    chk("dir_float_cycles", f, 32'd4);
    chk("dir_oe5", {31'd0, bus.oe_bidir[5]}, 32'd0);
    chk("dir_ie5", {31'd0, bus.ie_bidir[5]}, 32'd1);
    chk("dir_pd5", {31'd0, bus.pd_bidir[5]}, 32'd1);
    @(posedge clk);
    #1;
    chk("dir_done_once", {31'd0, bus.cfg_done}, 32'd0);
    chk("dir_ready_after", {31'd0, bus.cfg_ready}, 32'd1);

    // Illegal requests: bad index, then bad pull code.
    drive(4'd15, 1'b0, 2'b00);
    wait_accept(w);
    bus.cfg_valid = 1'b0;
    chk("ill_idx_err", {31'd0, bus.cfg_err}, 32'd1);
    chk("ill_idx_done", {31'd0, bus.cfg_done}, 32'd0);
    chk("ill_idx_oe", {17'd0, bus.oe_bidir}, {17'd0, m_oe});
    @(posedge clk);
    #1;
    chk("ill_idx_err_once", {31'd0, bus.cfg_err}, 32'd0);
    drive(4'd3, 1'b0, 2'b11);
    wait_accept(w);
    bus.cfg_valid = 1'b0;
    chk("ill_pull_err", {31'd0, bus.cfg_err}, 32'd1);
    chk("ill_pull_pu", {17'd0, bus.pu_bidir}, {17'd0, m_pu});
    chk("ill_pull_pd", {17'd0, bus.pd_bidir}, {17'd0, m_pd});
    @(posedge clk);
    #1;

    // Second request held through a settle; first request's inputs change after capture.
    drive(4'd6, 1'b0, 2'b01);
    wait_accept(w);
    drive(4'd1, 1'b1, 2'b00);
    wait_accept(w);
    bus.cfg_valid = 1'b0;
    chk("busy_wait_cycles", w, 32'd4);
    chk("busy_pad1_float", {30'd0, bus.oe_bidir[1], bus.ie_bidir[1]}, 32'd0);
    wait_done(1, f);
    chk("busy_float_cycles", f, 32'd4);
    chk("busy_oe1", {31'd0, bus.oe_bidir[1]}, 32'd1);
    chk("busy_ie1", {31'd0, bus.ie_bidir[1]}, 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a settle sequence.
    drive(4'd5, 1'b1, 2'b00);
    wait_accept(w);
    bus.cfg_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk("mid_rst_oe5", {31'd0, bus.oe_bidir[5]}, 32'd1);
    chk("mid_rst_ie5", {31'd0, bus.ie_bidir[5]}, 32'd0);
    chk("mid_rst_oe", {17'd0, bus.oe_bidir}, {17'd0, ROE});
    chk("mid_rst_pd", {17'd0, bus.pd_bidir}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.cfg_ready}, 32'd1);
    chk("mid_rst_done", {31'd0, bus.cfg_done}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_done", {31'd0, bus.cfg_done}, 32'd0);
      chk("post_rst_ready", {31'd0, bus.cfg_ready}, 32'd1);
    end

    // Back-to-back single-cycle updates on the same pad.
    drive(4'd2, 1'b0, 2'b10);
    wait_accept(w);
    chk("b2b_first_wait", w, 32'd0);
    chk("b2b_pd2_set", {31'd0, bus.pd_bidir[2]}, 32'd1);
    drive(4'd2, 1'b0, 2'b00);
    wait_accept(w);
    bus.cfg_valid = 1'b0;
    chk("b2b_second_wait", w, 32'd0);
    chk("b2b_done", {31'd0, bus.cfg_done}, 32'd1);
    chk("b2b_pd2_clr", {31'd0, bus.pd_bidir[2]}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    chk("sb_drained", sb.size(), 32'd0);
    chk("done_pulses", done_seen, 32'd6);
    chk("err_pulses", err_seen, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
